// File: rtl/mcpu_avl_req_queue.sv
// Command queue between the ltc2mc Avalon master and the memory controller.
// A DEPTH-entry FIFO feeds one presented-command register; reads are capped at MAX_RD in flight.
module mcpu_avl_req_queue #(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 8
) (
    input  logic         clkrst_avl_clk,
    input  logic         clkrst_avl_rst,
    input  logic         mc_ready,
    input  logic         up_read_req,
    input  logic         up_write_req,
    input  logic [24:0]  up_addr,
    input  logic [15:0]  up_be,
    input  logic [127:0] up_wdata,
    input  logic [4:0]   up_size,
    output logic         up_ready,
    output logic [127:0] up_rdata,
    output logic         up_rdata_valid,
    output logic         mc_avl_read_req,
    output logic         mc_avl_write_req,
    output logic         mc_avl_burstbegin,
    output logic [24:0]  mc_avl_addr,
    output logic [15:0]  mc_avl_be,
    output logic [127:0] mc_avl_wdata,
    output logic [4:0]   mc_avl_size,
    input  logic         mc_avl_ready,
    input  logic [127:0] mc_avl_rdata,
    input  logic         mc_avl_rdata_valid,
    output logic [7:0]   rd_outstanding,
    output logic         err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]  MAX_RD_C = 8'(MAX_RD);

    typedef enum logic {ST_CAL = 1'b0, ST_RUN = 1'b1} state_t;

    state_t state;
    state_t state_nxt;
    logic   load_en;

    logic          fifo_wr    [DEPTH];
    logic [24:0]   fifo_addr  [DEPTH];
    logic [15:0]   fifo_be    [DEPTH];
    logic [127:0]  fifo_wdata [DEPTH];
    logic [4:0]    fifo_size  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic out_valid;
    logic out_write;
    logic enq;
    logic load;
    logic accept;
    logic head_write;
    logic rd_gate_ok;
    logic rd_inc;
    logic rd_dec;
    logic rd_orphan;

    assign up_ready   = (fifo_cnt != FULL_CNT);
    assign enq        = (up_read_req | up_write_req) & up_ready;
    assign head_write = fifo_wr[rd_ptr];
    assign rd_gate_ok = head_write | (rd_outstanding < MAX_RD_C);
    assign accept     = out_valid & mc_avl_ready;
    // A held command blocks the next load until the controller takes it.
    assign load       = load_en & (fifo_cnt != '0) & (!out_valid | accept) & rd_gate_ok;

    assign rd_inc    = load & !head_write;
    assign rd_dec    = mc_avl_rdata_valid & (rd_outstanding != 8'd0);
    assign rd_orphan = mc_avl_rdata_valid & (rd_outstanding == 8'd0);

    assign mc_avl_read_req  = out_valid & !out_write;
    assign mc_avl_write_req = out_valid & out_write;

    // FSM: state register
    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) state <= ST_CAL;
        else                state <= state_nxt;
    end

    // FSM: next state; leaving RUN waits for the presented command to drain
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CAL:  if (mc_ready) state_nxt = ST_RUN;
            ST_RUN:  if (!mc_ready && !out_valid) state_nxt = ST_CAL;
            default: state_nxt = ST_CAL;
        endcase
    end

    // FSM: outputs
    always_comb begin
        load_en = (state == ST_RUN) & mc_ready;
    end

    // Command storage; a read+write collision is stored as a write.
    always_ff @(posedge clkrst_avl_clk) begin
        if (enq) begin
            fifo_wr[wr_ptr]    <= up_write_req;
            fifo_addr[wr_ptr]  <= up_addr;
            fifo_be[wr_ptr]    <= up_be;
            fifo_wdata[wr_ptr] <= up_wdata;
            fifo_size[wr_ptr]  <= up_size;
        end
    end

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq)  wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, load})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            out_valid         <= 1'b0;
            out_write         <= 1'b0;
            mc_avl_addr       <= '0;
            mc_avl_be         <= '0;
            mc_avl_wdata      <= '0;
            mc_avl_size       <= '0;
            mc_avl_burstbegin <= 1'b0;
        end else begin
            mc_avl_burstbegin <= load;
            if (load) begin
                out_valid    <= 1'b1;
                out_write    <= head_write;
                mc_avl_addr  <= fifo_addr[rd_ptr];
                mc_avl_be    <= fifo_be[rd_ptr];
                mc_avl_wdata <= fifo_wdata[rd_ptr];
                mc_avl_size  <= fifo_size[rd_ptr];
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Read accounting and single-register return path; orphan data is dropped.
    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            rd_outstanding <= 8'd0;
            err_sticky     <= 1'b0;
            up_rdata_valid <= 1'b0;
            up_rdata       <= '0;
        end else begin
            case ({rd_inc, rd_dec})
                2'b10:   rd_outstanding <= rd_outstanding + 8'd1;
                2'b01:   rd_outstanding <= rd_outstanding - 8'd1;
                default: rd_outstanding <= rd_outstanding;
            endcase
            if ((enq & up_read_req & up_write_req) | rd_orphan) err_sticky <= 1'b1;
            up_rdata_valid <= rd_dec;
            if (rd_dec) up_rdata <= mc_avl_rdata;
        end
    end

endmodule

// File: tb/tb_mcpu_avl_req_queue.sv
// Scoreboard bench for mcpu_avl_req_queue: issued commands and returned data are
// checked against queues filled when the stimulus is driven.
module tb_mcpu_avl_req_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mc_ready = 1'b0;
    logic         up_read_req = 1'b0;
    logic         up_write_req = 1'b0;
    logic [24:0]  up_addr = '0;
    logic [15:0]  up_be = '0;
    logic [127:0] up_wdata = '0;
    logic [4:0]   up_size = '0;
    logic         up_ready;
    logic [127:0] up_rdata;
    logic         up_rdata_valid;
    logic         mc_avl_read_req;
    logic         mc_avl_write_req;
    logic         mc_avl_burstbegin;
    logic [24:0]  mc_avl_addr;
    logic [15:0]  mc_avl_be;
    logic [127:0] mc_avl_wdata;
    logic [4:0]   mc_avl_size;
    logic         mc_avl_ready = 1'b0;
    logic [127:0] mc_avl_rdata = '0;
    logic         mc_avl_rdata_valid = 1'b0;
    logic [7:0]   rd_outstanding;
    logic         err_sticky;

    mcpu_avl_req_queue #(.DEPTH(4), .MAX_RD(8)) dut (
        .clkrst_avl_clk     (clk),
        .clkrst_avl_rst     (rst),
        .mc_ready           (mc_ready),
        .up_read_req        (up_read_req),
        .up_write_req       (up_write_req),
        .up_addr            (up_addr),
        .up_be              (up_be),
        .up_wdata           (up_wdata),
        .up_size            (up_size),
        .up_ready           (up_ready),
        .up_rdata           (up_rdata),
        .up_rdata_valid     (up_rdata_valid),
        .mc_avl_read_req    (mc_avl_read_req),
        .mc_avl_write_req   (mc_avl_write_req),
        .mc_avl_burstbegin  (mc_avl_burstbegin),
        .mc_avl_addr        (mc_avl_addr),
        .mc_avl_be          (mc_avl_be),
        .mc_avl_wdata       (mc_avl_wdata),
        .mc_avl_size        (mc_avl_size),
        .mc_avl_ready       (mc_avl_ready),
        .mc_avl_rdata       (mc_avl_rdata),
        .mc_avl_rdata_valid (mc_avl_rdata_valid),
        .rd_outstanding     (rd_outstanding),
        .err_sticky         (err_sticky)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {write, addr, be, wdata, size} of every command expected on the Avalon side
    logic [174:0] exp_q[$];
    logic [127:0] rexp_q[$];
    int           acc_cyc[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [174:0] pack(input logic w, input logic [24:0] a,
                                          input logic [15:0] be, input logic [127:0] d,
                                          input logic [4:0] sz);
        return {w, a, be, d, sz};
    endfunction

    // Issue monitor: acceptance happens at the next posedge when req & mc_avl_ready.
    always @(negedge clk) begin
        if (!rst && (mc_avl_read_req || mc_avl_write_req) && mc_avl_ready) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("issue_unexp", 1, 0);
            else chk("issue", {mc_avl_write_req, mc_avl_addr, mc_avl_be, mc_avl_wdata, mc_avl_size},
                     exp_q.pop_front());
        end
        if (up_rdata_valid) begin
            if (rexp_q.size() == 0) chk("ret_unexp", 1, 0);
            else chk("ret_data", up_rdata, rexp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic enq(input logic rd, input logic wr, input logic [24:0] a,
                       input logic [15:0] be, input logic [127:0] d);
        int n = 0;
        while (!up_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!up_ready) chk("enq_timeout", 0, 1);
        up_read_req  = rd;
        up_write_req = wr;
        up_addr      = a;
        up_be        = be;
        up_wdata     = d;
        up_size      = 5'd1;
        exp_q.push_back(pack(wr, a, be, d, 5'd1));
        @(posedge clk); #1;
        up_read_req  = 1'b0;
        up_write_req = 1'b0;
    endtask

    task automatic ret(input logic [127:0] d, input logic fwd);
        @(posedge clk); #1;
        mc_avl_rdata       = d;
        mc_avl_rdata_valid = 1'b1;
        if (fwd) rexp_q.push_back(d);
        @(posedge clk); #1;
        mc_avl_rdata_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || rexp_q.size() != 0) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size() + rexp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_up_ready"}, up_ready, 1);
        chk({tag, "_reqs"}, {mc_avl_read_req, mc_avl_write_req, mc_avl_burstbegin}, 0);
        chk({tag, "_addr"}, mc_avl_addr, 0);
        chk({tag, "_wdata"}, mc_avl_wdata, 0);
        chk({tag, "_rd_out"}, rd_outstanding, 0);
        chk({tag, "_err"}, err_sticky, 0);
        chk({tag, "_rvalid"}, {up_rdata_valid, up_rdata}, 0);
    endtask

    initial begin
        logic [127:0] bp_data;
        logic [127:0] dead_data;
        int n;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Calibration hold
        mc_avl_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            enq(1'b0, 1'b1, 25'h40 + 25'(i), 16'(16'hF000 >> i), 128'(32'hA000 + i));
        chk("cal_up_ready_full", up_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("cal_no_write", mc_avl_write_req, 0);
        end
        chk("cal_pending", exp_q.size(), 4);
        acc_cyc.delete();
        @(posedge clk); #1;
        mc_ready = 1'b1;
        wait_drain(50);
        chk("cal_count", acc_cyc.size(), 4);
        if (acc_cyc.size() == 4)
            for (int i = 0; i < 3; i++) chk("cal_b2b", acc_cyc[i+1] - acc_cyc[i], 1);

        // Backpressure
        mc_avl_ready = 1'b0;
        bp_data = {$urandom, $urandom, $urandom, $urandom};
        enq(1'b0, 1'b1, 25'h100, 16'h0FF0, bp_data);
        n = 0;
        @(negedge clk);
        while (!mc_avl_write_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_seen", mc_avl_write_req, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold", {mc_avl_write_req, mc_avl_addr, mc_avl_be, mc_avl_wdata},
                {1'b1, 25'h100, 16'h0FF0, bp_data});
            chk("bp_burstbegin", mc_avl_burstbegin, (i == 0));
        end
        @(posedge clk); #1;
        mc_avl_ready = 1'b1;
        @(negedge clk);
        chk("bp_6th_present", mc_avl_write_req, 1);
        wait_drain(20);

        // Read gate: 10 reads, no data back
        for (int i = 0; i < 10; i++) enq(1'b1, 1'b0, 25'h1000 + 25'(i), 16'h0, 128'h0);
        idle(6);
        chk("gate_rd_out", rd_outstanding, 8);
        chk("gate_stalled", exp_q.size(), 2);
        chk("gate_no_req", mc_avl_read_req, 0);
        ret(128'h1, 1'b1);
        idle(4);
        chk("gate_9th_issued", exp_q.size(), 1);
        chk("gate_rd_out_9", rd_outstanding, 8);
        for (int i = 0; i < 9; i++) ret(128'(32'h100 + i), 1'b1);
        wait_drain(40);
        chk("gate_rd_out_0", rd_outstanding, 0);

        // Ordering with the gate closed
        for (int i = 0; i < 8; i++) enq(1'b1, 1'b0, 25'h200 + 25'(i), 16'h0, 128'h0);
        enq(1'b0, 1'b1, 25'h10, 16'hFFFF, 128'h11);
        enq(1'b1, 1'b0, 25'h10, 16'h0, 128'h0);
        enq(1'b0, 1'b1, 25'h20, 16'hFFFF, 128'h22);
        idle(6);
        chk("order_stalled", exp_q.size(), 2);
        for (int i = 0; i < 9; i++) ret(128'($urandom), 1'b1);
        wait_drain(40);
        chk("order_rd_out_0", rd_outstanding, 0);

        // Return latency
        enq(1'b1, 1'b0, 25'h300, 16'h0, 128'h0);
        wait_drain(20);
        dead_data = 128'hDEAD0000_11112222_33334444_0000BEEF;
        mc_avl_rdata       = dead_data;
        mc_avl_rdata_valid = 1'b1;
        rexp_q.push_back(dead_data);
        @(negedge clk);
        chk("lat_not_early", up_rdata_valid, 0);
        @(posedge clk); #1;
        mc_avl_rdata_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1", {up_rdata_valid, up_rdata}, {1'b1, dead_data});
        @(negedge clk);
        chk("lat_pulse", up_rdata_valid, 0);

        // Read+write collision
        chk("err_clear", err_sticky, 0);
        enq(1'b1, 1'b1, 25'h55, 16'h00FF, 128'h5555);
        wait_drain(20);
        chk("err_both", err_sticky, 1);
        chk("err_both_rd_out", rd_outstanding, 0);

        // Reset, then orphan read data
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst2");
        @(posedge clk); #1;
        rst = 1'b0;
        ret(128'hBAD, 1'b0);
        idle(2);
        chk("orphan_err", err_sticky, 1);
        chk("orphan_rd_out", rd_outstanding, 0);

        // Reset mid-burst
        mc_avl_ready = 1'b0;
        idle(3);
        for (int i = 0; i < 3; i++) enq(1'b0, 1'b1, 25'h700 + 25'(i), 16'hFFFF, 128'(i));
        enq(1'b1, 1'b0, 25'h7F0, 16'h0, 128'h0);
        idle(2);
        chk("mid_presented", mc_avl_write_req, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        mc_avl_ready = 1'b1;
        idle(8);
        chk("mid_dropped", {mc_avl_read_req, mc_avl_write_req}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
